// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receive path.
//   OVERSAMPLE  ticks per bit period (16x oversampling)
//   MID_SAMPLE  tick index inside the start bit where the line is re-checked
//   ST_*        state encodings, also used by rx_state_t
//   even_parity helper returning the even-parity bit of a data byte
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } rx_state_t;

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO for received bytes.
//   clk, reset  system clock, synchronous active-high reset
//   push, din   write din this cycle (dropped when full unless pop also occurs)
//   pop         advance head this cycle (ignored when empty)
//   full, empty occupancy flags
//   dout        current head, forced to 0 while empty
//   count       occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of 2 so the pointers wrap by natural overflow.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_COUNT);
   assign count = count_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   // A pop frees the slot the simultaneous push needs, so full+pop+push
   // performs both and occupancy stays at DEPTH.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: dout is masked while empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receiver with a FWFT byte FIFO.
//   clk, reset  system clock, synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   rd_en       pop the FIFO head (ignored when empty)
//   clr_err     clear the sticky error flags
//   rx_data     FIFO head, valid while rx_valid=1
//   rx_valid    FIFO non-empty; rx_irq mirrors it as a level interrupt
//   overrun     sticky: byte arrived while FIFO full and not popping
//   frame_err   sticky: stop bit sampled 0
//   parity_err  sticky: even-parity mismatch (only with UART_RX_PARITY_EN)
// Build option: define UART_RX_PARITY_EN to add an even parity bit after the
// data bits; without it the frame is plain 8N1.
// Valid/ready: the FIFO presents a byte whenever rx_valid=1; a byte is
// consumed exactly on a cycle where rx_valid=1 and rd_en=1.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_irq,
   output logic       overrun,
   output logic       frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int TICK_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SAMPLE_W = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0]   TICK_MAX    = TICK_W'(DIV - 1);
   localparam logic [SAMPLE_W-1:0] MID_TICK    = SAMPLE_W'(MID_SAMPLE);
   localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(OVERSAMPLE - 1);

   logic                  sync1_q, sync1_d;
   logic                  sync2_q, sync2_d;
   logic                  prev_q, prev_d;
   rx_state_t             state_q, state_d;
   logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic [SAMPLE_W-1:0]   sample_q, sample_d;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            shift_q, shift_d;
   logic                  overrun_q, overrun_d;
   logic                  frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic                  parity_bad_q, parity_bad_d;
   logic                  parity_err_q, parity_err_d;
   logic                  parity_set;
`endif

   logic                  rx_s;
   logic                  start_edge;
   logic                  tick;
   logic                  push_byte;
   logic                  frame_set;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [7:0]            fifo_dout;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                  unused_count;

   assign rx_s       = sync2_q;
   assign start_edge = prev_q & ~sync2_q;
   assign tick       = (state_q != IDLE) && (tick_cnt_q == TICK_MAX);
   // Occupancy is kept visible for observation only.
   assign unused_count = ^fifo_count;

   always_comb begin
      sync1_d    = rx;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      state_d    = state_q;
      sample_d   = sample_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      push_byte  = 1'b0;
      frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_d = parity_bad_q;
      parity_set   = 1'b0;
`endif

      // The divider only runs inside a frame so every frame starts phase-aligned
      // to its own start edge.
      if (state_q == IDLE || tick) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d  = START;
               sample_d = '0;
`ifdef UART_RX_PARITY_EN
               parity_bad_d = 1'b0;
`endif
            end
         end
         START: begin
            if (tick) begin
               if (sample_q == MID_TICK) begin
                  // A line that is high again at mid start bit was a glitch.
                  sample_d = '0;
                  bit_d    = '0;
                  state_d  = rx_s ? IDLE : DATA;
               end else begin
                  sample_d = sample_q + SAMPLE_W'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (sample_q == LAST_SAMPLE) begin
                  sample_d = '0;
                  shift_d  = {rx_s, shift_q[7:1]};
                  bit_d    = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end else begin
                  sample_d = sample_q + SAMPLE_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (sample_q == LAST_SAMPLE) begin
                  sample_d = '0;
                  state_d  = STOP;
                  if (rx_s != even_parity(shift_q)) begin
                     parity_bad_d = 1'b1;
                     parity_set   = 1'b1;
                  end
               end else begin
                  sample_d = sample_q + SAMPLE_W'(1);
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (sample_q == LAST_SAMPLE) begin
                  sample_d = '0;
                  state_d  = IDLE;
                  if (!rx_s) begin
                     frame_set = 1'b1;
                  end else begin
`ifdef UART_RX_PARITY_EN
                     push_byte = ~parity_bad_q;
`else
                     push_byte = 1'b1;
`endif
                  end
               end else begin
                  sample_d = sample_q + SAMPLE_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Set events take priority over a coincident clear.
      overrun_d   = (push_byte & fifo_full & ~rd_en) ? 1'b1 :
                    (clr_err ? 1'b0 : overrun_q);
      frame_err_d = frame_set ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_set ? 1'b1 : (clr_err ? 1'b0 : parity_err_q);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         prev_q      <= 1'b1;
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         sample_q    <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         sample_q    <= sample_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         parity_bad_q <= parity_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   uart_rx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_byte),
      .din   (shift_q),
      .pop   (rd_en),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign rx_data   = fifo_dout;
   assign rx_valid  = ~fifo_empty;
   assign rx_irq    = ~fifo_empty;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver at DIV=10
// (160 clocks per bit). Define UART_RX_PARITY_EN for the parity build.
`timescale 1ns/1ps
module tb_uart_receiver;
   import uart_pkg::*;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 10_000;
   localparam int DEPTH    = 4;
   localparam int BIT_CLKS = 160;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_irq;
   logic       overrun;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   always #5 clk = ~clk;

   uart_receiver #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_irq    (rx_irq),
      .overrun   (overrun),
      .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Start bit, data bits LSB first and (when built in) the parity bit.
   task automatic send_head(input logic [7:0] d, input logic par_b);
      rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_clks(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      rx = par_b;
      wait_clks(BIT_CLKS);
`endif
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
      send_head(d, par_b);
      rx = stop_b;
      wait_clks(BIT_CLKS);
      rx = 1'b1;
      if (!stop_b) wait_clks(BIT_CLKS);
   endtask

   task automatic clear_errors();
      clr_err = 1'b1;
      wait_clks(1);
      clr_err = 1'b0;
      wait_clks(1);
   endtask

   task automatic pop_check(input string name);
      logic [7:0] e;
      check({name, " valid"}, 32'(rx_valid), 32'(1));
      e = exp_q.pop_front();
      check({name, " data"}, 32'(rx_data), 32'(e));
      rd_en = 1'b1;
      wait_clks(1);
      rd_en = 1'b0;
   endtask

   task automatic drain(input string name);
      while (exp_q.size() > 0) pop_check(name);
      check({name, " empty"}, 32'(rx_valid), 32'(0));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      logic       stop_b;
      logic       exp_push;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      int n;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0};

      reset   = 1'b1;
      rx      = 1'b1;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      wait_clks(4);

      // Reset state
      check("reset rx_valid", 32'(rx_valid), 32'(0));
      check("reset rx_irq", 32'(rx_irq), 32'(0));
      check("reset rx_data", 32'(rx_data), 32'(0));
      check("reset overrun", 32'(overrun), 32'(0));
      check("reset frame_err", 32'(frame_err), 32'(0));
      check("reset state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b0;
      wait_clks(20);

      // Test 1: 0xA5, rx_valid shortly after the stop-bit mid-sample
      send_head(8'hA5, ^8'hA5);
      rx = 1'b1;
      n  = 0;
      while (n < 120 && !rx_valid) begin
         wait_clks(1);
         n++;
      end
      check("t1 valid latency ok", 32'((n >= 81) && (n <= 85)), 32'(1));
      check("t1 rx_irq", 32'(rx_irq), 32'(1));
      check("t1 frame_err", 32'(frame_err), 32'(0));
      exp_q.push_back(8'hA5);
      if (n < BIT_CLKS) wait_clks(BIT_CLKS - n);
      drain("t1");

      // Test 2: 40-clock glitch does not start a frame
      rx = 1'b0;
      wait_clks(20);
      check("t2 state start", 32'(dut.state_q), 32'(START));
      wait_clks(20);
      rx = 1'b1;
      wait_clks(120);
      check("t2 state idle", 32'(dut.state_q), 32'(IDLE));
      check("t2 rx_valid", 32'(rx_valid), 32'(0));

      // Table: single frames, including a bad stop bit (0x3C)
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].stop_b, ^vecs[i].data);
         if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
         check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
         check($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'(vecs[i].exp_push));
`ifdef UART_RX_PARITY_EN
         check($sformatf("vec%0d parity_err", i), 32'(parity_err), 32'(0));
`endif
         drain($sformatf("vec%0d", i));
         clear_errors();
         check($sformatf("vec%0d frame_err clr", i), 32'(frame_err), 32'(0));
      end

      // Test 4: five bytes into a 4-deep FIFO without reads
      for (int b = 1; b <= 5; b++) begin
         send_frame(8'(b), 1'b1, ^(8'(b)));
         if (b <= DEPTH) exp_q.push_back(8'(b));
      end
      check("t4 overrun", 32'(overrun), 32'(1));
      drain("t4");
      clear_errors();
      check("t4 overrun clr", 32'(overrun), 32'(0));

      // Test 5: full FIFO, pop on the push cycle of 0x77
      send_frame(8'h11, 1'b1, ^8'h11); exp_q.push_back(8'h11);
      send_frame(8'h22, 1'b1, ^8'h22); exp_q.push_back(8'h22);
      send_frame(8'h33, 1'b1, ^8'h33); exp_q.push_back(8'h33);
      send_frame(8'h44, 1'b1, ^8'h44); exp_q.push_back(8'h44);
      check("t5 count full", 32'(dut.fifo_count), 32'(4));
      send_head(8'h77, ^8'h77);
      rx = 1'b1;
      wait_clks(82);
      check("t5 head", 32'(rx_data), 32'(exp_q.pop_front()));
      rd_en = 1'b1;
      wait_clks(1);
      rd_en = 1'b0;
      exp_q.push_back(8'h77);
      check("t5 overrun", 32'(overrun), 32'(0));
      check("t5 count", 32'(dut.fifo_count), 32'(4));
      wait_clks(BIT_CLKS - 83);
      drain("t5");

      // Test 6: reset during data bit 3 of 0xFF, then 0x12
      rx = 1'b0;
      wait_clks(BIT_CLKS);
      rx = 1'b1;
      wait_clks(3 * BIT_CLKS + 80);
      reset = 1'b1;
      wait_clks(3);
      reset = 1'b0;
      wait_clks(200);
      check("t6 state idle", 32'(dut.state_q), 32'(IDLE));
      check("t6 rx_valid", 32'(rx_valid), 32'(0));
      send_frame(8'h12, 1'b1, ^8'h12);
      exp_q.push_back(8'h12);
      check("t6 frame_err", 32'(frame_err), 32'(0));
      drain("t6");
`ifdef UART_RX_PARITY_EN
      send_frame(8'h12, 1'b1, ~(^8'h12));
      check("t6 parity_err", 32'(parity_err), 32'(1));
      check("t6 bad parity dropped", 32'(rx_valid), 32'(0));
      clear_errors();
      check("t6 parity_err clr", 32'(parity_err), 32'(0));
`endif

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
